rgb_pwm_ctrl: RTL

Controller that drives the three RGB LED sink pads. Per channel it generates the `rgb_pwm` modulation strobe and the static 6-bit current-enable code `cbit_rgb`; the pad sinks current only while both are active. Adds per-channel duty shadowing and a shared blink (on/off) sequencer, all configured through a simple register write port from the SoC bus.

---
 rtl/rgb_pwm_ctrl.sv | 129 ++++++++++++
 1 files changed

// File: rtl/rgb_pwm_ctrl.sv
// RGB LED pad controller: per-channel PWM with shadowed duty, static current codes, shared blink sequencer.
// Latency: register writes visible next cycle; rgb_pwm lags pwm_cnt by one clk, first high 2 clks after led_en.
// Backpressure: none; write port is a fire-and-forget strobe and outputs free-run.
module rgb_pwm_ctrl #(
    parameter int PWM_BITS   = 8,
    parameter int BLINK_BITS = 8
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       led_en,
    input  logic       wr_en,
    input  logic [2:0] wr_addr,
    input  logic [7:0] wr_data,
    output logic [2:0] rgb_pwm,
    output logic [5:0] cbit_rgb0,
    output logic [5:0] cbit_rgb1,
    output logic [5:0] cbit_rgb2,
    output logic       blink_on
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        ON   = 2'd1,
        OFF  = 2'd2
    } state_t;

    localparam logic [PWM_BITS-1:0] PWM_MAX = '1;

    state_t                state;
    logic [PWM_BITS-1:0]   duty     [3];
    logic [PWM_BITS-1:0]   duty_act [3];
    logic [BLINK_BITS-1:0] on_time;
    logic [BLINK_BITS-1:0] off_time;
    logic [PWM_BITS-1:0]   pwm_cnt;
    logic [BLINK_BITS-1:0] blink_cnt;
    logic [BLINK_BITS-1:0] blink_inc;
    logic                  boundary;

    assign boundary  = (pwm_cnt == PWM_MAX);
    assign blink_inc = blink_cnt + BLINK_BITS'(1);

    // Configuration registers; the cbit registers drive the pads directly.
    always_ff @(posedge clk) begin
        if (rst) begin
            duty      <= '{default: '0};
            on_time   <= '0;
            off_time  <= '0;
            cbit_rgb0 <= '0;
            cbit_rgb1 <= '0;
            cbit_rgb2 <= '0;
        end else if (wr_en) begin
            case (wr_addr)
                3'd0: duty[0]   <= PWM_BITS'(wr_data);
                3'd1: duty[1]   <= PWM_BITS'(wr_data);
                3'd2: duty[2]   <= PWM_BITS'(wr_data);
                3'd3: cbit_rgb0 <= wr_data[5:0];
                3'd4: cbit_rgb1 <= wr_data[5:0];
                3'd5: cbit_rgb2 <= wr_data[5:0];
                3'd6: on_time   <= BLINK_BITS'(wr_data);
                default: off_time <= BLINK_BITS'(wr_data);
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            pwm_cnt   <= '0;
            blink_cnt <= '0;
            duty_act  <= '{default: '0};
            rgb_pwm   <= '0;
            blink_on  <= 1'b0;
        end else if (!led_en) begin
            state     <= IDLE;
            pwm_cnt   <= '0;
            blink_cnt <= '0;
            rgb_pwm   <= '0;
            blink_on  <= 1'b0;
        end else begin
            case (state)
                ON, OFF: begin
                    pwm_cnt <= pwm_cnt + PWM_BITS'(1);
                    for (int i = 0; i < 3; i++) begin
                        rgb_pwm[i] <= (state == ON) && (pwm_cnt < duty_act[i]);
                    end
                    if (boundary) begin
                        // Duty writes landing on this same edge are seen at the next boundary.
                        duty_act <= duty;
                        if (state == ON) begin
                            if (blink_inc == on_time) begin
                                blink_cnt <= '0;
                                if (off_time != '0) begin
                                    state    <= OFF;
                                    blink_on <= 1'b0;
                                end
                            end else begin
                                blink_cnt <= blink_inc;
                            end
                        end else begin
                            if (blink_inc == off_time) begin
                                blink_cnt <= '0;
                                if (on_time != '0) begin
                                    state    <= ON;
                                    blink_on <= 1'b1;
                                end
                            end else begin
                                blink_cnt <= blink_inc;
                            end
                        end
                    end
                end
                default: begin
                    pwm_cnt   <= '0;
                    blink_cnt <= '0;
                    duty_act  <= duty;
                    rgb_pwm   <= '0;
                    if (on_time == '0) begin
                        state    <= OFF;
                        blink_on <= 1'b0;
                    end else begin
                        state    <= ON;
                        blink_on <= 1'b1;
                    end
                end
            endcase
        end
    end

endmodule
